// File: rtl/second_row_enemy_ctrl.sv
// rtl/second_row_enemy_ctrl.sv - second-row enemy life cycle, step/phase counting and position register
// Enemy walks ALIVE -> DYING -> DEAD; position is always a registered copy, never a pass-through.
module second_row_enemy_ctrl #(
   parameter logic [9:0] NONE        = 10'b11_1111_1111,
   parameter logic [9:0] START_X     = 10'd64,
   parameter logic [5:0] STEP_COUNT  = 6'd32,
   parameter logic [3:0] DEATH_TICKS = 4'd8
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_MoveTick,
   input  logic       i_Hit,
   input  logic       i_Respawn,
   input  logic [9:0] i_NextHorizontalPosition,
   output logic       o_EnemyState,
   output logic [9:0] o_EnemyHorizontalPosition,
   output logic [1:0] o_PhaseState,
   output logic       o_Exploding,
   output logic       o_PhaseWrap,
   output logic       o_Killed
);

   typedef enum logic [1:0] {ALIVE, DYING, DEAD} state_t;

   state_t     state, state_next;
   logic [9:0] pos, pos_next;
   logic [1:0] phase, phase_next;
   logic [5:0] step_cnt, step_next;
   logic [3:0] death_cnt, death_next;
   logic       wrap, wrap_next;
   logic       killed, killed_next;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= ALIVE;
         pos       <= START_X;
         phase     <= 2'd0;
         step_cnt  <= 6'd0;
         death_cnt <= 4'd0;
         wrap      <= 1'b0;
         killed    <= 1'b0;
      end else begin
         state     <= state_next;
         pos       <= pos_next;
         phase     <= phase_next;
         step_cnt  <= step_next;
         death_cnt <= death_next;
         wrap      <= wrap_next;
         killed    <= killed_next;
      end
   end

   always_comb begin
      state_next  = state;
      pos_next    = pos;
      phase_next  = phase;
      step_next   = step_cnt;
      death_next  = death_cnt;
      wrap_next   = 1'b0;
      killed_next = 1'b0;
      case (state)
         ALIVE: begin
            // A hit in the same cycle as a move tick wins, so the position freezes where it was hit.
            if (i_Hit) begin
               state_next  = DYING;
               death_next  = 4'd0;
               killed_next = 1'b1;
            end else if (i_MoveTick) begin
               pos_next = i_NextHorizontalPosition;
               if (step_cnt == STEP_COUNT - 6'd1) begin
                  step_next  = 6'd0;
                  phase_next = phase + 2'd1;
                  wrap_next  = (phase == 2'd3);
               end else begin
                  step_next = step_cnt + 6'd1;
               end
            end
         end
         DYING: begin
            if (i_MoveTick) begin
               if (death_cnt == DEATH_TICKS - 4'd1) begin
                  state_next = DEAD;
                  pos_next   = NONE;
                  death_next = 4'd0;
               end else begin
                  death_next = death_cnt + 4'd1;
               end
            end
         end
         DEAD: begin
            if (i_Respawn) begin
               state_next = ALIVE;
               pos_next   = START_X;
               phase_next = 2'd0;
               step_next  = 6'd0;
               death_next = 4'd0;
            end
         end
         default: state_next = ALIVE;
      endcase
   end

   assign o_EnemyState              = (state == ALIVE);
   assign o_Exploding               = (state == DYING);
   assign o_EnemyHorizontalPosition = pos;
   assign o_PhaseState              = phase;
   assign o_PhaseWrap               = wrap;
   assign o_Killed                  = killed;

endmodule

// File: tb/tb_second_row_enemy_ctrl.sv
// tb/tb_second_row_enemy_ctrl.sv - directed vector table plus random run against a tick-count reference model
module tb_second_row_enemy_ctrl;

   localparam int STEP  = 4;
   localparam int DEATH = 2;
   localparam logic [9:0] NONE_POS = 10'h3FF;
   localparam logic [9:0] START    = 10'd64;

   logic       clk = 1'b0;
   logic       rst, move_tick, hit, respawn;
   logic [9:0] next_pos;
   logic       enemy_state, exploding, phase_wrap, killed;
   logic [9:0] enemy_pos;
   logic [1:0] phase_state;

   second_row_enemy_ctrl #(
      .NONE(10'b11_1111_1111), .START_X(10'd64), .STEP_COUNT(6'd4), .DEATH_TICKS(4'd2)
   ) dut (
      .i_Clk(clk), .i_Rst(rst), .i_MoveTick(move_tick), .i_Hit(hit), .i_Respawn(respawn),
      .i_NextHorizontalPosition(next_pos),
      .o_EnemyState(enemy_state), .o_EnemyHorizontalPosition(enemy_pos),
      .o_PhaseState(phase_state), .o_Exploding(exploding),
      .o_PhaseWrap(phase_wrap), .o_Killed(killed)
   );

   always #5 clk = ~clk;

   // Conforming move stage: +1 in phases 00/11, -1 in phases 01/10.
   assign next_pos = (phase_state == 2'd0 || phase_state == 2'd3) ? enemy_pos + 10'd1 : enemy_pos - 10'd1;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: life stage plus total ticks walked since spawn; phase is derived arithmetically.
   int         m_life;   // 0 alive, 1 exploding, 2 dead
   int         m_moves;
   int         m_dticks;
   logic [9:0] m_pos;
   bit         m_wrap, m_kill;

   function automatic int m_phase();
      return (m_moves / STEP) % 4;
   endfunction

   task automatic model_step(input bit t, input bit h, input bit r, input bit s);
      m_wrap = 0;
      m_kill = 0;
      if (s) begin
         m_life = 0; m_pos = START; m_moves = 0; m_dticks = 0;
      end else if (m_life == 0) begin
         if (h) begin
            m_life = 1; m_dticks = 0; m_kill = 1;
         end else if (t) begin
            m_pos   = (m_phase() == 0 || m_phase() == 3) ? m_pos + 10'd1 : m_pos - 10'd1;
            m_moves = (m_moves + 1) % (4 * STEP);
            m_wrap  = (m_moves == 0);
         end
      end else if (m_life == 1) begin
         if (t) begin
            m_dticks++;
            if (m_dticks == DEATH) begin
               m_life = 2; m_pos = NONE_POS;
            end
         end
      end else if (r) begin
         m_life = 0; m_pos = START; m_moves = 0;
      end
   endtask

   task automatic run_cycle(input bit t, input bit h, input bit r, input bit s, input string tag);
      move_tick = t; hit = h; respawn = r; rst = s;
      model_step(t, h, r, s);
      @(posedge clk);
      #1;
      check({tag, " m.alive"}, {9'd0, enemy_state}, {9'd0, m_life == 0});
      check({tag, " m.expl"},  {9'd0, exploding},   {9'd0, m_life == 1});
      check({tag, " m.pos"},   enemy_pos,           m_pos);
      if (m_life == 0)
         check({tag, " m.phase"}, {8'd0, phase_state}, 10'(m_phase()));
      check({tag, " m.wrap"},  {9'd0, phase_wrap},  {9'd0, m_wrap});
      check({tag, " m.kill"},  {9'd0, killed},      {9'd0, m_kill});
   endtask

   typedef struct {
      bit         t, h, r, s;
      bit         e_alive;
      logic [9:0] e_pos;
      logic [1:0] e_phase;
      bit         e_expl, e_wrap, e_kill;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;

   task automatic add(input bit t, input bit h, input bit r, input bit s,
                      input bit al, input logic [9:0] p, input logic [1:0] ph,
                      input bit ex, input bit wr, input bit ki);
      vecs[nv] = '{t, h, r, s, al, p, ph, ex, wr, ki};
      nv++;
   endtask

   int walk[16] = '{65, 66, 67, 68, 67, 66, 65, 64, 63, 62, 61, 60, 61, 62, 63, 64};

   initial begin
      rst = 1'b1; move_tick = 1'b0; hit = 1'b0; respawn = 1'b0;
      m_life = 0; m_pos = START; m_moves = 0; m_dticks = 0; m_wrap = 0; m_kill = 0;

      add(0,0,0,1, 1,64,0, 0,0,0);                       // reset state
      for (int i = 0; i < 16; i++)                       // full 4-phase walk, wrap after tick 16
         add(1,0,0,0, 1,10'(walk[i]),2'(((i + 1) / 4) % 4), 0,(i == 15),0);
      add(0,0,0,0, 1,64,0, 0,0,0);
      add(0,0,1,0, 1,64,0, 0,0,0);                       // respawn ignored while alive
      add(1,0,0,0, 1,65,0, 0,0,0);
      add(1,0,0,0, 1,66,0, 0,0,0);
      add(1,1,0,0, 0,66,0, 1,0,1);                       // hit beats tick
      add(0,0,0,0, 0,66,0, 1,0,0);
      add(0,0,1,0, 0,66,0, 1,0,0);                       // respawn ignored while dying
      add(1,0,0,0, 0,66,0, 1,0,0);
      add(1,0,0,0, 0,10'h3FF,0, 0,0,0);                  // dead after DEATH ticks
      add(0,1,0,0, 0,10'h3FF,0, 0,0,0);
      add(1,1,0,0, 0,10'h3FF,0, 0,0,0);
      add(0,1,1,0, 1,64,0, 0,0,0);                       // respawn beats hit
      add(1,0,0,0, 1,65,0, 0,0,0);
      add(1,0,0,0, 1,66,0, 0,0,0);
      add(0,1,0,0, 0,66,0, 1,0,1);
      add(1,0,0,0, 0,66,0, 1,0,0);
      add(0,0,0,1, 1,64,0, 0,0,0);                       // reset while dying
      add(1,0,0,0, 1,65,0, 0,0,0);
      add(1,0,0,0, 1,66,0, 0,0,0);
      add(1,1,0,1, 1,64,0, 0,0,0);                       // reset mid-phase overrides tick and hit
      add(1,0,0,0, 1,65,0, 0,0,0);
      add(1,0,0,0, 1,66,0, 0,0,0);
      add(1,0,0,0, 1,67,0, 0,0,0);
      add(1,0,0,0, 1,68,1, 0,0,0);

      for (int i = 0; i < nv; i++) begin
         run_cycle(vecs[i].t, vecs[i].h, vecs[i].r, vecs[i].s, $sformatf("v%0d", i));
         check($sformatf("v%0d alive", i), {9'd0, enemy_state}, {9'd0, vecs[i].e_alive});
         check($sformatf("v%0d pos", i),   enemy_pos,           vecs[i].e_pos);
         check($sformatf("v%0d phase", i), {8'd0, phase_state}, {8'd0, vecs[i].e_phase});
         check($sformatf("v%0d expl", i),  {9'd0, exploding},   {9'd0, vecs[i].e_expl});
         check($sformatf("v%0d wrap", i),  {9'd0, phase_wrap},  {9'd0, vecs[i].e_wrap});
         check($sformatf("v%0d kill", i),  {9'd0, killed},      {9'd0, vecs[i].e_kill});
      end

      for (int c = 0; c < 3000; c++)
         run_cycle($urandom_range(1, 0) == 1, $urandom_range(59, 0) == 0,
                   $urandom_range(7, 0) == 0, $urandom_range(199, 0) == 0,
                   $sformatf("r%0d", c));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/second_row_enemy_ctrl.md
SECOND_ROW_ENEMY_CTRL -- requirements
Module: second_row_enemy_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NONE, 10'b11_1111_1111, off-screen position code.
- START_X, 10'd64, spawn/reset horizontal position.
- STEP_COUNT, 6'd32, move ticks per phase, legal range 2..63.
- DEATH_TICKS, 4'd8, move ticks spent exploding, legal range 1..15.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. Ports are listed one per line (name, direction, width, meaning):
- i_Clk, in, 1, system clock; all state updates on its rising edge.
- i_Rst, in, 1, synchronous active-high reset.
- i_MoveTick, in, 1, single-cycle move strobe (frame-rate pulse).
- i_Hit, in, 1, single-cycle projectile-collision pulse for this enemy.
- i_Respawn, in, 1, single-cycle respawn request.
- i_NextHorizontalPosition, in, 10, next position from the row move stage.
- o_EnemyState, out, 1, 1 = enemy alive.
- o_EnemyHorizontalPosition, out, 10, registered current position, or NONE.
- o_PhaseState, out, 2, current movement phase, fed to the move stage.
- o_Exploding, out, 1, high while the explosion sprite is shown.
- o_PhaseWrap, out, 1, one-cycle pulse when the phase wraps 11->00.
- o_Killed, out, 1, one-cycle pulse on the ALIVE->DYING transition.

Function
REQ-003 The FSM SHALL have three states: ALIVE, DYING, DEAD. State is encoded internally, and the encoding is not visible at the ports.
REQ-004 o_EnemyState SHALL be 1 only in ALIVE; o_Exploding SHALL be 1 only in DYING.
REQ-005 In ALIVE, on a cycle with i_MoveTick=1 and i_Hit=0, position SHALL load i_NextHorizontalPosition and the 6-bit step counter SHALL increment.
REQ-006 When the step counter equals STEP_COUNT-1 on such a tick, the counter SHALL clear to 0 and o_PhaseState SHALL advance 00->01->10->11->00.
REQ-007 The phase advance SHALL take effect on the same edge as the position load.
REQ-008 o_PhaseWrap SHALL pulse for exactly the one cycle after the 11->00 advance.
REQ-009 In ALIVE, when i_MoveTick=0, position, counter and phase SHALL hold.
REQ-010 In ALIVE, i_Hit=1 SHALL transition to DYING, pulse o_Killed for one cycle, clear the death counter, and freeze position, phase and step counter.
REQ-011 When i_Hit=1 and i_MoveTick=1 arrive in the same cycle, the hit SHALL win and the position SHALL NOT update.
REQ-012 In DYING, each i_MoveTick SHALL increment the death counter. On the tick where it equals DEATH_TICKS-1, the FSM SHALL go to DEAD and position SHALL load NONE.
REQ-013 i_Hit SHALL be ignored in DYING and DEAD.
REQ-014 i_Respawn SHALL be honoured only in DEAD: next state ALIVE, position START_X, phase 00, step counter 0. It SHALL be ignored in ALIVE and DYING.
REQ-015 In DEAD, when i_Respawn and i_Hit arrive in the same cycle, the respawn SHALL win and the enemy SHALL be alive the next cycle.
REQ-016 o_EnemyHorizontalPosition SHALL be a register output, with no combinational path from any input.
REQ-017 The phase register SHALL wrap modulo 4, and the step and death counters SHALL never exceed their limits.
REQ-018 Net displacement over a full 4-phase cycle with a conforming move stage (+1 in phases 00/11, -1 in phases 01/10) SHALL be zero. Position therefore returns to its phase-00 entry value.

Reset
REQ-019 On i_Rst=1 at a clock edge, the block SHALL enter ALIVE with o_EnemyHorizontalPosition=START_X, o_PhaseState=00, step and death counters 0, and o_EnemyState=1.
REQ-020 On the same reset, o_Exploding, o_PhaseWrap and o_Killed SHALL be 0.
REQ-021 i_Rst SHALL override all other inputs in the same cycle, including in mid-phase and in DYING.

Verification
REQ-022 Bench parameters SHALL be STEP_COUNT=4 and DEATH_TICKS=2, with the move stage modelled as +1 in phases 00/11 and -1 in phases 01/10. The bench SHALL cover these directed scenarios:
- Reset, then 4 ticks -> position 64->68, phase 01.
- 16 ticks from reset -> position 64,68,64,60,64 at each phase boundary; o_PhaseWrap pulses once after tick 16.
- Hit at pos 66 with a tick in the same cycle -> o_Killed pulses, position stays 66, o_Exploding=1, o_EnemyState=0.
- Then 2 ticks -> DEAD, position 0x3FF; extra i_Hit pulses leave the state unchanged.
- In DEAD, i_Respawn with i_Hit in the same cycle -> ALIVE next cycle, position 64, phase 00.
- i_Rst asserted in DYING after 1 tick -> ALIVE next cycle, position 64, all pulse outputs 0.
